sccb_bus_arbiter: RTL and testbench
===================================

// Module: sccb_bus_arbiter
// PURPOSE
//  Shares the single I2C/SCCB master engine between NUM_REQ register-write requesters.
//  Typical requesters: the boot-time ROM config sequencer and a runtime exposure/gain tweak port.
//  Round-robin grant; one 16-bit {reg_addr,reg_data} write per grant.
//  Forwards the write to the engine (valid/ready/done) and returns a done or timeout-error pulse.
//  Sits between the requesters and the I2C engine, in the engine's clk_i domain.
// PARAMETERS
//  NUM_REQ         2      number of requesters (2..8)
//  DATA_W          16     write word width {reg_addr[15:8], reg_data[7:0]}
//  TIMEOUT_CYCLES  50000  clk_i cycles from ISSUE entry before abort (>=2)
// PORTS
//  clk_i        in   1               system clock
//  reset_n_i    in   1               asynchronous, active-low reset
//  req_valid_i  in   NUM_REQ         request pending, held until req_ready_o
//  req_data_i   in   NUM_REQ*DATA_W  request words, req k at [k*DATA_W +: DATA_W]
//  req_ready_o  out  NUM_REQ         1-cycle accept pulse; data latched this cycle
//  req_done_o   out  NUM_REQ         1-cycle completion pulse to the granted requester
//  req_err_o    out  NUM_REQ         1-cycle timeout pulse to the granted requester
//  eng_valid_o  out  1               write word valid to engine
//  eng_data_o   out  DATA_W          latched write word
//  eng_ready_i  in   1               engine idle and able to accept
//  eng_done_i   in   1               engine transaction complete (pulse)
//  busy_o       out  1               state != IDLE
//  grant_id_o   out  $clog2(NUM_REQ) index of current/last grant
// BEHAVIOUR
//  Reset (async, reset_n_i=0):
//   - state=IDLE; rr pointer=0; timer=0.
//   - All outputs 0, including eng_data_o and grant_id_o.
//   - Reset mid-transaction drops eng_valid_o at once; no done/err pulse is issued.
//  States: IDLE -> ISSUE -> WAIT_DONE -> IDLE.
//  IDLE:
//   - If any req_valid_i, grant the first set bit searching from ptr upward, wrapping mod NUM_REQ.
//   - Same cycle: req_ready_o[g]=1, latch data into eng_data_o, grant_id_o=g.
//   - Next: ptr=(g+1)%NUM_REQ, timer=0, go to ISSUE.
//  ISSUE:
//   - eng_valid_o=1. When eng_ready_i=1, go to WAIT_DONE.
//   - eng_valid_o falls the following cycle, so it is high >=1 cycle.
//  WAIT_DONE:
//   - On eng_done_i, pulse req_done_o[g] and go to IDLE.
//  Timer (ISSUE and WAIT_DONE):
//   - Counts +1 per cycle.
//   - At timer==TIMEOUT_CYCLES-1 with no done: pulse req_err_o[g], go to IDLE.
//   - Done and timeout in the same cycle: done wins, no err.
//  Ignored inputs:
//   - eng_done_i outside WAIT_DONE is ignored.
//   - req_valid_i changes outside IDLE are ignored.
//  Throughput: minimum 1 idle cycle between grants; no back-to-back in IDLE.
//  Latency: req_valid_i -> req_ready_o is 0 cycles when IDLE; eng_valid_o rises 1 cycle later.
// CONFIGURATION
//  SCCB_ARB_LOCK_EN defined:
//   - Adds port req_lock_i (in, NUM_REQ).
//   - If req_lock_i[g]=1 when returning to IDLE, ptr is not advanced and only requester g may be granted.
//   - Lock lasts until g completes a transaction with lock=0, or g holds valid=0 for 1 IDLE cycle.
//   - Timeout clears the lock.
//  SCCB_ARB_LOCK_EN undefined: no req_lock_i port; pure round-robin.
// STRUCTURE
//  Package sccb_arb_pkg:
//   - state_t enum {IDLE, ISSUE, WAIT_DONE}
//   - default parameter constants
//  Sub-module rr_pick: combinational
//   - Inputs: req vector, ptr.
//   - Outputs: grant one-hot, grant index, any-valid.
//   - Instantiated once.
// TESTING
//  1. Single req0 word 16'h1280, eng_ready=1, done 5 cycles later:
//     - ready0 pulse, eng_data=16'h1280, done0 1 cycle, busy back to 0.
//  2. req0 and req1 both valid continuously, 4 transactions:
//     - grant order 0,1,0,1; each grant_id matches its done pulse.
//  3. req1 only, eng_done never asserted, TIMEOUT_CYCLES=16:
//     - err1 pulse exactly 16 cycles after ISSUE entry; no done1; next grant proceeds.
//  4. eng_ready_i low for 10 cycles in ISSUE:
//     - eng_valid held 10+ cycles, data stable.
//  5. reset_n_i low during WAIT_DONE:
//     - eng_valid/done/err immediately 0; after release ptr=0, req1-only grants req1.
//  6. (SCCB_ARB_LOCK_EN) req0 lock=1 for 3 words while req1 valid:
//     - grants 0,0,0, then 1.

Source files
------------

// File: rtl/sccb_arb_pkg.sv
// rtl/sccb_arb_pkg.sv - shared state encoding and default parameters for the SCCB bus arbiter
package sccb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/sccb_bus_arbiter_rr_pick.sv
// rtl/sccb_bus_arbiter_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_valid && req[idx]) begin
                any_valid      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sccb_bus_arbiter.sv
// rtl/sccb_bus_arbiter.sv - round-robin arbiter sharing one SCCB write engine among requesters
// Optional requester lock enabled by defining SCCB_ARB_LOCK_EN.
module sccb_bus_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
`ifdef SCCB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          req_lock_i,
`endif
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          req_done_o,
    output logic [NUM_REQ-1:0]          req_err_o,
    output logic                        eng_valid_o,
    output logic [DATA_W-1:0]           eng_data_o,
    input  logic                        eng_ready_i,
    input  logic                        eng_done_i,
    output logic                        busy_o,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [TW-1:0]        timer;
    logic [DATA_W-1:0]    data_q;
    logic [IW-1:0]        grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_REQ-1:0]   err_q;

    logic [NUM_REQ-1:0]   pick_req;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IW-1:0]        next_ptr;
    logic                 timeout_hit;

    assign grant_oh    = NUM_REQ'(1) << grant_q;
    assign next_ptr    = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));

`ifdef SCCB_ARB_LOCK_EN
    logic lock_active;
    // While locked only the last-granted requester is visible to the picker.
    assign pick_req = lock_active ? (req_valid_i & grant_oh) : req_valid_i;
`else
    assign pick_req = req_valid_i;
`endif

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .IW       (IW)
    ) u_rr_pick (
        .req       (pick_req),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    assign req_ready_o = (state == IDLE && reset_n_i) ? pick_grant : '0;
    assign eng_valid_o = (state == ISSUE);
    assign busy_o      = (state != IDLE);
    assign eng_data_o  = data_q;
    assign grant_id_o  = grant_q;
    assign req_done_o  = done_q;
    assign req_err_o   = err_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            ptr     <= '0;
            timer   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
`ifdef SCCB_ARB_LOCK_EN
            lock_active <= 1'b0;
`endif
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        data_q  <= req_data_i[pick_idx*DATA_W +: DATA_W];
                        grant_q <= pick_idx;
                        ptr     <= next_ptr;
                        timer   <= '0;
                        state   <= ISSUE;
                    end
`ifdef SCCB_ARB_LOCK_EN
                    else if (lock_active && !req_valid_i[grant_q]) begin
                        lock_active <= 1'b0;
                    end
`endif
                end
                ISSUE: begin
                    timer <= timer + 1'b1;
                    if (timeout_hit) begin
                        err_q <= grant_oh;
                        state <= IDLE;
`ifdef SCCB_ARB_LOCK_EN
                        lock_active <= 1'b0;
`endif
                    end else if (eng_ready_i) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    timer <= timer + 1'b1;
                    // Done takes priority over a timeout landing in the same cycle.
                    if (eng_done_i) begin
                        done_q <= grant_oh;
                        state  <= IDLE;
`ifdef SCCB_ARB_LOCK_EN
                        if (req_lock_i[grant_q]) begin
                            lock_active <= 1'b1;
                            ptr         <= grant_q;
                        end else begin
                            lock_active <= 1'b0;
                        end
`endif
                    end else if (timeout_hit) begin
                        err_q <= grant_oh;
                        state <= IDLE;
`ifdef SCCB_ARB_LOCK_EN
                        lock_active <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_bus_arbiter.sv
// tb/tb_sccb_bus_arbiter.sv - directed self-checking bench for sccb_bus_arbiter
module tb_sccb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_lock;
    logic [1:0]  req_ready;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic        eng_valid;
    logic [15:0] eng_data;
    logic        eng_ready;
    logic        eng_done;
    logic        busy;
    logic        grant_id;

    int checks = 0;
    int passed = 0;

    sccb_bus_arbiter #(
        .NUM_REQ        (2),
        .DATA_W         (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
`ifdef SCCB_ARB_LOCK_EN
        .req_lock_i  (req_lock),
`endif
        .req_ready_o (req_ready),
        .req_done_o  (req_done),
        .req_err_o   (req_err),
        .eng_valid_o (eng_valid),
        .eng_data_o  (eng_data),
        .eng_ready_i (eng_ready),
        .eng_done_i  (eng_done),
        .busy_o      (busy),
        .grant_id_o  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One full write: wait for the grant, accept it, then complete it with a done pulse.
    task automatic run_txn(input int exp_id, input logic lock_val);
        int n;
        logic [15:0] exp_data;
        n = 0;
        exp_data = (exp_id == 1) ? req_data[31:16] : req_data[15:0];
        while (eng_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("txn_eng_valid", {31'd0, eng_valid}, 32'd1);
        chk("txn_grant_id", {31'd0, grant_id}, exp_id);
        chk("txn_eng_data", {16'd0, eng_data}, {16'd0, exp_data});
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        eng_done  = 1'b1;
        req_lock  = {1'b0, lock_val};
        settle();
        tick();
        eng_done = 1'b0;
        settle();
        chk("txn_done", {30'd0, req_done}, 32'd1 << exp_id);
    endtask

    initial begin
        int bad;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = 32'h0;
        req_lock  = 2'b00;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        tick();
        chk("reset_outputs", {26'd0, req_ready, req_done, req_err}, 32'd0);
        chk("reset_eng", {13'd0, eng_valid, busy, grant_id, eng_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0
        req_valid = 2'b01;
        req_data  = 32'h0000_1280;
        settle();
        chk("t1_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        settle();
        chk("t1_issue", {14'd0, eng_valid, busy, eng_data}, {14'd0, 2'b11, 16'h1280});
        chk("t1_ready_drop", {30'd0, req_ready}, 32'd0);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        settle();
        chk("t1_wait", {30'd0, eng_valid, busy}, 32'd1);
        repeat (4) tick();
        eng_done = 1'b1;
        settle();
        tick();
        eng_done = 1'b0;
        settle();
        chk("t1_done", {29'd0, busy, req_done}, 32'd1);
        tick();
        chk("t1_done_pulse", {30'd0, req_done}, 32'd0);

        // Reset from idle clears latched data and the pointer
        rst_n = 1'b0;
        settle();
        chk("rst_clears_data", {15'd0, grant_id, eng_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Both requesters continuously valid: alternate from 0
        req_valid = 2'b11;
        req_data  = 32'h2222_1111;
        settle();
        chk("t2_first_ready", {30'd0, req_ready}, 32'd1);
        for (int t = 0; t < 4; t++) run_txn(t % 2, 1'b0);
        req_valid = 2'b00;

        // Requester 1 alone, engine never completes: timeout
        req_valid = 2'b10;
        req_data  = 32'h3344_0000;
        settle();
        chk("t3_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        repeat (14) tick();
        chk("t3_before_timeout", {29'd0, busy, req_err}, 32'h4);
        tick();
        chk("t3_err", {27'd0, busy, req_done, req_err}, 32'h2);
        tick();
        chk("t3_err_pulse", {30'd0, req_err}, 32'd0);

        // Next grant proceeds; engine holds off ready for 10 cycles
        req_valid = 2'b01;
        req_data  = 32'h3344_5566;
        settle();
        chk("t4_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(eng_valid === 1'b1 && eng_data === 16'h5566)) bad++;
            tick();
        end
        chk("t4_hold_bad_cycles", bad, 32'd0);
        chk("t4_still_valid", {31'd0, eng_valid}, 32'd1);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        settle();
        chk("t4_wait", {30'd0, eng_valid, busy}, 32'd1);

        // Reset during WAIT_DONE, with a done arriving at the same moment
        eng_done = 1'b1;
        rst_n    = 1'b0;
        settle();
        chk("t5_async_drop", {28'd0, eng_valid, busy, req_err}, 32'd0);
        tick();
        chk("t5_no_pulse", {28'd0, req_done, req_err}, 32'd0);
        rst_n     = 1'b1;
        eng_done  = 1'b0;
        req_valid = 2'b10;
        settle();
        chk("t5_ready1", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        chk("t5_grant1", {15'd0, grant_id, eng_data}, {15'd0, 1'b1, 16'h3344});
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        eng_done  = 1'b1;
        tick();
        eng_done = 1'b0;
        settle();
        chk("t5_done1", {30'd0, req_done}, 32'd2);

`ifdef SCCB_ARB_LOCK_EN
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_data  = 32'hAAAA_0B0B;
        tick();
        run_txn(0, 1'b1);
        run_txn(0, 1'b1);
        run_txn(0, 1'b0);
        run_txn(1, 1'b0);
        req_valid = 2'b00;
        req_lock  = 2'b00;
`endif

        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
